// File: rtl/ula_control_mc.sv
// Registered ALU-control decoder with mult/div sequencing (start pulse, stall, done pulse).
// Define ULA_CTRL_ILLEGAL_EN to flag unknown R-type funct codes instead of decoding them as add.
module ula_control_mc #(
    parameter int CTRL_W    = 4,
    parameter int FUNCT_W   = 6,
    parameter int MD_CYCLES = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid_in,
    input  logic               flush,
    input  logic [1:0]         OpALU,
    input  logic [FUNCT_W-1:0] funct,
    output logic [CTRL_W-1:0]  inputALU,
    output logic               out_valid,
    output logic [1:0]         md_op,
    output logic               md_start,
    output logic               md_done,
    output logic               stall,
    output logic               illegal,
    output logic [1:0]         state_dbg
);

    localparam int CNT_W = $clog2(MD_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [CTRL_W-1:0] dec_code;
    logic              dec_md;
    logic              dec_ill;
    logic [5:0]        fn;

    assign fn        = funct[5:0];
    assign state_dbg = state;

    always_comb begin
        dec_code = CTRL_W'(4'b0010);
        dec_md   = 1'b0;
        dec_ill  = 1'b0;
        case (OpALU)
            2'b00: dec_code = CTRL_W'(4'b0010);
            2'b01: dec_code = CTRL_W'(4'b0110);
            2'b11: dec_code = CTRL_W'(4'b0001);
            default: begin
                case (fn)
                    6'b100000, 6'b100001: dec_code = CTRL_W'(4'b0010);
                    6'b100010, 6'b100011: dec_code = CTRL_W'(4'b0110);
                    6'b100100:            dec_code = CTRL_W'(4'b0000);
                    6'b100101:            dec_code = CTRL_W'(4'b0001);
                    6'b101010:            dec_code = CTRL_W'(4'b0111);
                    6'b101011:            dec_code = CTRL_W'(4'b1000);
                    6'b100110:            dec_code = CTRL_W'(4'b1101);
                    6'b100111:            dec_code = CTRL_W'(4'b1100);
                    6'b011000, 6'b011001, 6'b011010, 6'b011011: dec_md = 1'b1;
                    default: begin
`ifdef ULA_CTRL_ILLEGAL_EN
                        dec_code = '1;
                        dec_ill  = 1'b1;
`else
                        dec_code = CTRL_W'(4'b0010);
`endif
                    end
                endcase
            end
        endcase
    end

    // valid/ready: an op is taken when valid_in=1 and the block is not BUSY (DONE accepts
    // like IDLE); while BUSY the stall output tells the pipeline to hold its inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            inputALU  <= '0;
            out_valid <= 1'b0;
            md_op     <= 2'b00;
            md_start  <= 1'b0;
            md_done   <= 1'b0;
            stall     <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            md_start  <= 1'b0;
            md_done   <= 1'b0;
            out_valid <= 1'b0;
            illegal   <= 1'b0;
            if (flush) begin
                state <= IDLE;
                stall <= 1'b0;
                cnt   <= '0;
            end else begin
                case (state)
                    BUSY: begin
                        if (cnt == '0) begin
                            state   <= DONE;
                            md_done <= 1'b1;
                            stall   <= 1'b0;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        if (valid_in) begin
                            if (dec_md) begin
                                state    <= BUSY;
                                md_start <= 1'b1;
                                md_op    <= funct[1:0];
                                stall    <= 1'b1;
                                // stall already counts the start cycle, so load one less
                                cnt      <= CNT_W'(MD_CYCLES - 1);
                            end else begin
                                inputALU  <= dec_code;
                                out_valid <= 1'b1;
                                illegal   <= dec_ill;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule
